atm_txn_controller: RTL

// - Sequences one ATM session: card insert -> 4-digit PIN entry with retry limit -> withdrawal amount -> dispense/eject.
// - Consumes single-cycle key pulses produced by the per-key edge-detect FSMs.
// - Owns the account balance register and the card-lock state.
// - Drives the dispenser, card-eject mechanism and status display.

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_txn_controller_if.sv | 30 +++
 rtl/atm_timeout_ctr.sv | 36 +++
 rtl/atm_txn_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction controller.
// State codes double as the display encoding on state_code.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIN      = 3'd1,
        ST_CHECK    = 3'd2,
        ST_AMOUNT   = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_EJECT    = 3'd5,
        ST_LOCKED   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_PIN = 2'd1;
    localparam logic [1:0] ERR_FUNDS   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int PIN_DIGITS = 4;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_txn_controller_if.sv
// Key/amount inputs and status/actuator outputs of the ATM controller.
// slave is the controller's view, master is the keypad/panel side.
interface atm_txn_controller_if #(
    parameter int BAL_W = 16
);
    logic             card_in;
    logic             digit_valid;
    logic [3:0]       digit;
    logic             enter_pulse;
    logic             cancel_pulse;
    logic [BAL_W-1:0] amount;

    logic [2:0]       state_code;
    logic             dispense;
    logic [BAL_W-1:0] dispense_amt;
    logic             eject;
    logic             card_locked;
    logic [1:0]       error_code;
    logic [BAL_W-1:0] balance;

    modport slave (
        input  card_in, digit_valid, digit, enter_pulse, cancel_pulse, amount,
        output state_code, dispense, dispense_amt, eject, card_locked, error_code, balance
    );

    modport master (
        output card_in, digit_valid, digit, enter_pulse, cancel_pulse, amount,
        input  state_code, dispense, dispense_amt, eject, card_locked, error_code, balance
    );
endinterface

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter: counts while enabled, restarts on clr, and flags
// expire when TIMEOUT_CYC-1 is reached with no clear in that cycle.
module atm_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_txn_controller.sv
// ATM session sequencer: card -> PIN (with lockout) -> amount -> dispense -> eject.
// All outputs are registered; pulses are raised on entry into DISPENSE/EJECT.
module atm_txn_controller
    import atm_pkg::*;
#(
    parameter logic [15:0]      PIN_CODE     = 16'h1234,
    parameter int               MAX_TRIES    = 3,
    parameter int               BAL_W        = 16,
    parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(500),
    parameter int               TIMEOUT_CYC  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    atm_txn_controller_if.slave  bus
);
    state_t           state_q, state_d;
    logic [15:0]      pin_q, pin_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       tries_q, tries_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic             disp_q, disp_d;
    logic [BAL_W-1:0] disp_amt_q, disp_amt_d;
    logic             eject_q, eject_d;
    logic             locked_q, locked_d;
    logic [1:0]       err_q, err_d;

    logic        tmo_en, tmo_clr, tmo_expire;
    logic [2:0]  cnt_new;
    logic [15:0] pin_new;
    logic [2:0]  tries_inc;

    assign tmo_en  = (state_q == ST_PIN) || (state_q == ST_AMOUNT);
    assign tmo_clr = bus.digit_valid || bus.enter_pulse;

    atm_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    assign tries_inc = tries_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        cnt_d      = cnt_q;
        tries_d    = tries_q;
        bal_d      = bal_q;
        disp_d     = 1'b0;
        disp_amt_d = '0;
        eject_d    = 1'b0;
        locked_d   = locked_q;
        err_d      = err_q;
        cnt_new    = cnt_q;
        pin_new    = pin_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.card_in) begin
                    state_d = ST_PIN;
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                    pin_d   = '0;
                end
            end
            ST_PIN: begin
                if (bus.cancel_pulse) begin
                    state_d = ST_EJECT;
                end else if (!bus.card_in) begin
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_EJECT;
                end else begin
                    // Digit is absorbed before enter looks at the count.
                    if (bus.digit_valid && is_bcd(bus.digit) && cnt_q < 3'(PIN_DIGITS)) begin
                        pin_new = {pin_q[11:0], bus.digit};
                        cnt_new = cnt_q + 3'd1;
                    end
                    pin_d = pin_new;
                    cnt_d = cnt_new;
                    if (bus.enter_pulse && cnt_new == 3'(PIN_DIGITS)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (bus.cancel_pulse) begin
                    state_d = ST_EJECT;
                end else if (pin_q == PIN_CODE) begin
                    tries_d = '0;
                    state_d = ST_AMOUNT;
                end else begin
                    tries_d = tries_inc;
                    err_d   = ERR_BAD_PIN;
                    if (tries_inc == 3'(MAX_TRIES)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_PIN;
                        cnt_d   = '0;
                        pin_d   = '0;
                    end
                end
            end
            ST_AMOUNT: begin
                if (bus.cancel_pulse) begin
                    state_d = ST_EJECT;
                end else if (!bus.card_in) begin
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_EJECT;
                end else if (bus.enter_pulse && bus.amount != '0) begin
                    if (bus.amount > bal_q) begin
                        err_d   = ERR_FUNDS;
                        state_d = ST_EJECT;
                    end else begin
                        // Debit together with the pulse so balance and dispense agree.
                        disp_d     = 1'b1;
                        disp_amt_d = bus.amount;
                        bal_d      = bal_q - bus.amount;
                        state_d    = ST_DISPENSE;
                    end
                end
            end
            ST_DISPENSE: state_d = ST_EJECT;
            ST_EJECT: begin
                if (!bus.card_in) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_EJECT && state_q != ST_EJECT) begin
            eject_d = 1'b1;
        end
        if (state_d == ST_LOCKED) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pin_q      <= '0;
            cnt_q      <= '0;
            tries_q    <= '0;
            bal_q      <= INIT_BALANCE;
            disp_q     <= 1'b0;
            disp_amt_q <= '0;
            eject_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pin_q      <= pin_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            bal_q      <= bal_d;
            disp_q     <= disp_d;
            disp_amt_q <= disp_amt_d;
            eject_q    <= eject_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign bus.state_code   = state_q;
    assign bus.dispense     = disp_q;
    assign bus.dispense_amt = disp_amt_q;
    assign bus.eject        = eject_q;
    assign bus.card_locked  = locked_q;
    assign bus.error_code   = err_q;
    assign bus.balance      = bal_q;

endmodule
